// File: rtl/sync_filter_pkg.sv
// ============================================================================
// Module   : sync_filter_pkg
// Brief    : Shared limits and counter-width helper for sync_filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_filter_pkg;

  localparam int MIN_STAGES   = 2;
  localparam int MIN_DEBOUNCE = 1;

  // Width of a counter that must hold values 0..debounce.
  function automatic int cnt_width(input int debounce);
    return (debounce < 1) ? 1 : $clog2(debounce + 1);
  endfunction

endpackage : sync_filter_pkg

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// Module   : sync_chain
// Brief    : N-bit multi-flop synchroniser; STAGES flops per bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain
  import sync_filter_pkg::*;
#(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_chain: STAGES must be at least %0d", MIN_STAGES);
  end

  logic [N-1:0] r_chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_chain[k] <= '0;
      end
    end else begin
      r_chain[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign q = r_chain[STAGES-1];

endmodule : sync_chain

`default_nettype wire

// File: rtl/sync_filter.sv
// ============================================================================
// Module   : sync_filter
// Brief    : Multi-channel synchroniser with optional debounce, edge pulses
//            and sticky acknowledged change flags.
//            Define SYNC_FILTER_DEBOUNCE_EN to include the debounce counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int N        = 1,
  parameter int STAGES   = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] indata,
  output logic [N-1:0] outdata,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] pending,
  input  logic [N-1:0] ack
);

  if (N < 1) begin : g_bad_n
    $error("sync_filter: N must be at least 1");
  end
  if (DEBOUNCE < MIN_DEBOUNCE) begin : g_bad_debounce
    $error("sync_filter: DEBOUNCE must be at least %0d", MIN_DEBOUNCE);
  end

  logic [N-1:0] w_s;

  sync_chain #(
    .N      (N),
    .STAGES (STAGES)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .d     (indata),
    .q     (w_s)
  );

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic r_out;
    logic r_rise;
    logic r_fall;
    logic r_pend;
    logic w_accept;

`ifdef SYNC_FILTER_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] c_last = CW'(DEBOUNCE - 1);

    logic [CW-1:0] r_cnt;

    assign w_accept = (w_s[i] != r_out) && (r_cnt == c_last);

    // Any cycle that agrees with the current level discards a partial count.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if ((w_s[i] == r_out) || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
`else
    assign w_accept = (w_s[i] != r_out);
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        r_out  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_pend <= 1'b0;
      end else begin
        if (w_accept) begin
          r_out <= w_s[i];
        end
        r_rise <= w_accept &  w_s[i];
        r_fall <= w_accept & ~w_s[i];
        // A new edge outranks a simultaneous acknowledge.
        r_pend <= r_rise | r_fall | (r_pend & ~ack[i]);
      end
    end

    assign outdata[i] = r_out;
    assign rise[i]    = r_rise;
    assign fall[i]    = r_fall;
    assign pending[i] = r_pend;
  end

endmodule : sync_filter

`default_nettype wire

// File: tb/tb_sync_filter.sv
// ============================================================================
// Module   : tb_sync_filter
// Brief    : Self-checking bench for sync_filter (N=4, STAGES=2, DEBOUNCE=4),
//            honouring SYNC_FILTER_DEBOUNCE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_filter;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;
`ifdef SYNC_FILTER_DEBOUNCE_EN
  localparam int DEFF = D;
`else
  localparam int DEFF = 1;
`endif
  localparam int L  = S + DEFF;
  localparam int HL = S + DEFF - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] indata = '0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] outdata, rise, fall, pending;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sync_filter #(
    .N        (N),
    .STAGES   (S),
    .DEBOUNCE (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .indata  (indata),
    .outdata (outdata),
    .rise    (rise),
    .fall    (fall),
    .pending (pending),
    .ack     (ack)
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: history of sampled inputs; a level is accepted once the last
  // DEFF synchronised samples all disagree with the current output level.
  logic [N-1:0] hist [HL];
  logic [N-1:0] m_out, m_rise, m_fall, m_pend, m_nout;
  bit           m_valid = 1'b0;
  bit           m_allne;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_out = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      m_valid = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_allne = 1'b1;
        for (int k = 0; k < DEFF; k++)
          if (hist[S-1+k][i] == m_out[i]) m_allne = 1'b0;
        m_nout[i] = m_allne ? ~m_out[i] : m_out[i];
      end
      m_pend = m_rise | m_fall | (m_pend & ~ack);
      m_rise = m_nout & ~m_out;
      m_fall = ~m_nout & m_out;
      m_out  = m_nout;
      for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = indata;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("model_outdata", outdata, m_out);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_pending", pending, m_pend);
    end
  end

  initial begin
    // Reset with inputs high, then power-on rise on every channel.
    indata = '1;
    reset  = 1'b1;
    repeat (3) tick();
    check("rst_outdata", outdata, '0);
    check("rst_rise", rise, '0);
    check("rst_fall", fall, '0);
    check("rst_pending", pending, '0);
    reset = 1'b0;
    repeat (L - 1) tick();
    check("por_before", outdata, '0);
    tick();
    check("por_outdata", outdata, 4'hF);
    check("por_rise", rise, 4'hF);
    tick();
    check("por_rise_end", rise, '0);
    check("por_pending", pending, 4'hF);
    ack = '1;
    tick();
    ack = '0;
    check("ack_clear", pending, '0);

    indata = '0;
    repeat (L + 2) tick();
    ack = '1;
    tick();
    ack = '0;
    tick();

`ifdef SYNC_FILTER_DEBOUNCE_EN
    // Pulse one cycle shorter than the debounce window is rejected.
    indata[0] = 1'b1;
    repeat (DEFF - 1) tick();
    indata[0] = 1'b0;
    for (int i = 0; i < L + 3; i++) begin
      tick();
      check("glitch_rise", rise, '0);
      check("glitch_pending", pending, '0);
    end
`endif

    // Minimum-width pulse is accepted and released.
    indata[0] = 1'b1;
    for (int i = 1; i <= L + DEFF; i++) begin
      tick();
      if (i == DEFF) indata[0] = 1'b0;
      if (i == L) check("pulse_rise", rise, 4'b0001);
      if (i == L + DEFF) check("pulse_fall", fall, 4'b0001);
    end
    repeat (L + 2) tick();
    ack = '1;
    tick();
    ack = '0;

    // Pending handshake on channel 2.
    indata[2] = 1'b1;
    repeat (L) tick();
    check("hs_rise", rise, 4'b0100);
    ack[2] = 1'b1;
    tick();
    check("hs_set_wins", pending, 4'b0100);
    tick();
    ack[2] = 1'b0;
    check("hs_cleared", pending, '0);

`ifdef SYNC_FILTER_DEBOUNCE_EN
    // Bounce on channel 1 yields a single rise after the final transition.
    indata[1] = 1'b1; tick();
    indata[1] = 1'b0; tick();
    indata[1] = 1'b1; tick();
    indata[1] = 1'b0; tick();
    indata[1] = 1'b1;
    for (int i = 1; i <= L; i++) begin
      tick();
      check("bounce_rise", rise, (i == L) ? 4'b0010 : 4'b0000);
    end
`else
    // Without the filter a one-cycle pulse passes as a one-cycle level.
    indata[0] = 1'b1;
    tick();
    indata[0] = 1'b0;
    repeat (L - 1) tick();
    check("nofilt_pulse_hi", outdata & 4'b0001, 4'b0001);
    tick();
    check("nofilt_pulse_lo", outdata & 4'b0001, 4'b0000);
`endif
    repeat (L + 2) tick();

    // Reset in the middle of an acceptance window on channel 3.
    indata[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef SYNC_FILTER_DEBOUNCE_EN
      check("midrst_early", rise & 4'b1000, '0);
`endif
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outdata", outdata, '0);
    for (int i = 1; i <= L; i++) begin
      tick();
      check("midrst_rise", rise & 4'b1000, (i == L) ? 4'b1000 : 4'b0000);
    end

    // Randomised traffic, checked by the reference on every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 3) == 0) indata = N'($urandom);
      ack   = N'($urandom & $urandom & $urandom);
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    ack   = '0;
    repeat (L + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_filter

`default_nettype wire

// File: doc/sync_filter.md
# sync_filter

Multi-channel clock-domain-crossing input conditioner: N asynchronous inputs pass through a configurable-depth flop chain, an optional per-channel debounce filter, and an edge detector. It produces a clean level, single-cycle rise/fall pulses, and a sticky change flag per channel that a consumer acknowledges. It sits at the boundary where external switches, keys and asynchronous status lines enter the processing clock domain, and replaces plain two-flop synchronisers wherever filtering or event capture is needed.

## Interface
Parameters:
- N, 1: channel count (≥1).
- STAGES, 2: synchroniser depth (≥2).
- DEBOUNCE, 4: consecutive stable cycles required to accept a new level (≥1); ignored when the debounce filter is compiled out.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising edge of clk while high.
- indata  input  N  asynchronous raw inputs.
- outdata  output  N  filtered, synchronised levels.
- rise  output  N  one-cycle pulse when the matching outdata bit goes 0→1.
- fall  output  N  one-cycle pulse when the matching outdata bit goes 1→0.
- pending  output  N  sticky flag, set by any rise or fall on that channel.
- ack  input  N  per-channel clear of pending; synchronous to clk.

## Operation
- Per channel: raw bit → STAGES-flop chain → s; s feeds the filter, whose registered level is outdata.
- Filter (debounce enabled): counter cnt, width $clog2(DEBOUNCE+1).
  - s == outdata: cnt ← 0.
  - s != outdata and cnt < DEBOUNCE-1: cnt ← cnt+1.
  - s != outdata and cnt == DEBOUNCE-1: outdata ← s, cnt ← 0, and rise or fall asserts in the same cycle as the outdata change.
  - Any cycle where s returns to outdata before acceptance discards the partial count (glitch rejected).
- Counter saturates by construction; it never wraps.
- rise/fall are registered and are high for exactly one cycle per transition; never both high on one channel.
- pending[i]: set when rise[i]|fall[i]; cleared when ack[i] is high and no new edge occurs that cycle. Simultaneous edge and ack: set wins, pending stays 1. ack on a clear flag has no effect.
- Channels are fully independent; no cross-channel ordering.
- reset high: all chain flops, cnt, outdata, rise, fall and pending become 0 at that edge. Mid-operation reset discards in-flight counts. After reset, an input held at 1 is reported as a fresh rise.

## Timing
- Reset values: outdata=0, rise=0, fall=0, pending=0.
- Latency, counting the edge that first samples the new indata value as edge 1: outdata, rise and fall change after edge STAGES+DEBOUNCE (debounce enabled) or edge STAGES+1 (disabled).
- pending sets one edge after the rise or fall pulse, i.e. registered from that pulse.
- Minimum accepted pulse width on indata is DEBOUNCE cycles. Shorter pulses produce no output activity.
- No combinational path from any input to any output.

## Configuration
- SYNC_FILTER_DEBOUNCE_EN defined: the counter filter above is present and DEBOUNCE applies.
- Not defined: counters are removed, DEBOUNCE is ignored, and outdata ← s every cycle. Behaviour is identical to DEBOUNCE=1 with the macro defined, including latency STAGES+1 and pulse/pending rules.

## Structure
- Package sync_filter_pkg holds MIN_STAGES=2 and MIN_DEBOUNCE=1 for elaboration-time parameter checks, plus a function returning the counter width for a given DEBOUNCE.
- Sub-module sync_chain (parameters N, STAGES; ports clk, reset, d, q) implements the flop chain, one instance for all N bits. Filter, edge and pending logic live in the top module in a per-channel generate loop.

## Test plan
- Reset: with indata=all-1s, hold reset 3 cycles → all outputs 0. After release, N=4, STAGES=2, DEBOUNCE=4: outdata=4'hF and rise=4'hF for one cycle after edge 6, then pending=4'hF.
- Glitch reject: a 3-cycle high pulse on indata[0] with DEBOUNCE=4 → outdata, rise and pending stay 0. A 4-cycle pulse → rise[0] after edge 6, fall[0] 4 cycles later.
- Bounce: toggle indata[1] 1,0,1,0 each cycle, then hold 1 → a single rise[1], exactly STAGES+DEBOUNCE edges after the final transition.
- Pending handshake: rise on channel 2 with ack[2]=1 in the same cycle pending would set → pending[2]=1. ack[2] pulse one cycle later → pending[2]=0 the next cycle.
- Reset mid-count: indata[3] rises, reset asserted after 3 cycles for 1 cycle → no rise before reset. rise[3] occurs STAGES+DEBOUNCE edges after reset release.
- Macro off, STAGES=3: indata[0] step 0→1 → outdata[0] and rise[0] after edge 4, and a 1-cycle input pulse propagates as a 1-cycle outdata pulse.
